// File: rtl/stage_pkg.sv
// Types and record layout shared by the stage generator and the stage renderer.
package stage_pkg;

  localparam int POS_DIGIT = 16;
  localparam int STAT_W    = 4;
  localparam int BLK_BITS  = 3 * POS_DIGIT + STAT_W;

  localparam int STAT_LSB   = 0;
  localparam int HEIGHT_LSB = STAT_LSB + STAT_W;
  localparam int RIGHT_LSB  = HEIGHT_LSB + POS_DIGIT;
  localparam int LEFT_LSB   = RIGHT_LSB + POS_DIGIT;

  localparam logic [STAT_W-1:0] STAT_BOT = 4'h0;
  localparam logic [STAT_W-1:0] STAT_TOP = 4'h1;

  typedef struct packed {
    logic [POS_DIGIT-1:0] left;
    logic [POS_DIGIT-1:0] right;
    logic [POS_DIGIT-1:0] height;
    logic [STAT_W-1:0]    stat;
  } blk_rec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN_BOT,
    ST_GEN_TOP,
    ST_WAIT,
    ST_END
  } state_e;

endpackage

// File: rtl/stage_gen_if.sv
// Control and read-port bundle between the stage generator and its consumer.
interface stage_gen_if #(
  parameter int ADDRW = 5
) ();

  logic                           i_start;
  logic [ADDRW-1:0]               i_rd_addr;
  logic [stage_pkg::BLK_BITS-1:0] o_rd_data;
  logic                           o_ready;
  logic                           o_end;

  modport slave  (input  i_start, i_rd_addr, output o_rd_data, o_ready, o_end);
  modport master (output i_start, i_rd_addr, input  o_rd_data, o_ready, o_end);

endinterface

// File: rtl/stage_gen_lfsr16.sv
// 16-bit right-shifting Galois LFSR that steps only when advanced.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] MASK = 16'hB400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q, state_d;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (adv_i) state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? MASK : 16'h0000);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/stage_gen.sv
// Procedural pipe-pair generator feeding a ring of block records read by the stage renderer.
module stage_gen
  import stage_pkg::*;
#(
  parameter int          ADDRW     = 5,
  parameter int          STG_DEPTH = 8,
  parameter int          V_RES     = 600,
  parameter int          FIRST_X   = 400,
  parameter int          PIPE_W    = 32,
  parameter int          GAP_MIN   = 96,
  parameter int          GAP_RW    = 6,
  parameter int          OPEN_H    = 160,
  parameter int          H_MIN     = 40,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input logic        i_clk_pix,
  input logic        i_rst,
  stage_gen_if.slave bus
);

  localparam int MEM_AW = $clog2(STG_DEPTH);
  localparam int OCC_W  = MEM_AW + 1;
  localparam int SW     = POS_DIGIT + 1;

  localparam logic [MEM_AW-1:0]    LAST_SLOT  = MEM_AW'(STG_DEPTH - 1);
  localparam logic [OCC_W-1:0]     OCC_FULL   = OCC_W'(STG_DEPTH);
  localparam logic [OCC_W-1:0]     OCC_REFILL = OCC_W'(STG_DEPTH - 2);
  localparam logic [POS_DIGIT-1:0] H_MAX      = POS_DIGIT'(V_RES - OPEN_H - H_MIN);
  localparam logic [POS_DIGIT-1:0] STACK_H    = POS_DIGIT'(V_RES - OPEN_H);
  localparam logic [POS_DIGIT-1:0] PREV_RST   = POS_DIGIT'(FIRST_X - GAP_MIN);

  state_e                 state_q, state_d;
  logic [MEM_AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [ADDRW-1:0]       rd_q;
  logic                   ready_q, ready_d;
  logic                   first_q;
  logic [POS_DIGIT-1:0]   prev_right_q;
  logic [15:0]            lfsr_q;
  logic [SW-1:0]          left_w, right_w;
  logic [POS_DIGIT-1:0]   top_h_raw, top_h, bot_h;
  logic                   overflow, wr_en, adv, consume;
  blk_rec_t               wr_rec;
  logic [BLK_BITS-1:0]    mem [STG_DEPTH];
  logic                   unused_lfsr;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk     (i_clk_pix),
    .rst     (i_rst),
    .adv_i   (adv),
    .state_o (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[7:GAP_RW];

  // Column geometry is derived from lfsr_q and prev_right_q, which stay constant across a pair.
  always_comb begin
    left_w    = first_q ? SW'(POS_DIGIT'(FIRST_X))
                        : SW'(prev_right_q) + SW'(1 + GAP_MIN) + SW'(lfsr_q[GAP_RW-1:0]);
    right_w   = left_w + SW'(PIPE_W - 1);
    overflow  = left_w[POS_DIGIT] | right_w[POS_DIGIT];
    top_h_raw = POS_DIGIT'(H_MIN) + POS_DIGIT'(lfsr_q[15:8]);
    top_h     = (top_h_raw > H_MAX) ? H_MAX : top_h_raw;
    bot_h     = STACK_H - top_h;
  end

  always_comb begin
    wr_rec.left   = left_w[POS_DIGIT-1:0];
    wr_rec.right  = right_w[POS_DIGIT-1:0];
    wr_rec.height = (state_q == ST_GEN_TOP) ? top_h : bot_h;
    wr_rec.stat   = (state_q == ST_GEN_TOP) ? STAT_TOP : STAT_BOT;
  end

  assign wr_en   = ((state_q == ST_GEN_BOT) && !overflow) || (state_q == ST_GEN_TOP);
  assign adv     = (state_q == ST_GEN_TOP);
  assign consume = (bus.i_rd_addr != rd_q) && (occ_q != '0);

  always_comb begin
    occ_d = occ_q;
    unique case ({wr_en, consume})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    wr_ptr_d = wr_ptr_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + MEM_AW'(1);
  end

  // Refill decisions look at the post-update occupancy so a consume is acted on immediately.
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    unique case (state_q)
      ST_IDLE:    if (bus.i_start) state_d = ST_GEN_BOT;
      ST_GEN_BOT: state_d = overflow ? ST_END : ST_GEN_TOP;
      ST_GEN_TOP: begin
        state_d = (occ_d <= OCC_REFILL) ? ST_GEN_BOT : ST_WAIT;
        if (occ_d == OCC_FULL) ready_d = 1'b1;
      end
      ST_WAIT:    if (occ_d <= OCC_REFILL) state_d = ST_GEN_BOT;
      ST_END:     state_d = ST_END;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_pix or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      rd_q         <= '0;
      ready_q      <= 1'b0;
      first_q      <= 1'b1;
      prev_right_q <= PREV_RST;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      rd_q     <= bus.i_rd_addr;
      ready_q  <= ready_d;
      if (adv) begin
        first_q      <= 1'b0;
        prev_right_q <= right_w[POS_DIGIT-1:0];
      end
    end
  end

  // NOTE: the record array has no reset; wr_en is derived from the reset state, so a reset aborts any write.
  always_ff @(posedge i_clk_pix) begin
    if (wr_en) mem[wr_ptr_q] <= wr_rec;
  end

  always_comb begin
    bus.o_rd_data = '0;
    if (int'(bus.i_rd_addr) < STG_DEPTH) bus.o_rd_data = mem[bus.i_rd_addr[MEM_AW-1:0]];
  end

  assign bus.o_ready = ready_q;
  assign bus.o_end   = (state_q == ST_END);

endmodule

// File: tb/tb_stage_gen.sv
// Directed bench for stage_gen: fill, refill, wrap, reset abort and coordinate overflow.
`timescale 1ns/100ps
module tb_stage_gen;
  import stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #10 clk = ~clk;

  stage_gen_if #(.ADDRW(5)) if_a ();
  stage_gen_if #(.ADDRW(5)) if_b ();

  stage_gen dut_a (.i_clk_pix(clk), .i_rst(rst), .bus(if_a.slave));
  stage_gen #(.FIRST_X(16'hFFF0)) dut_b (.i_clk_pix(clk), .i_rst(rst), .bus(if_b.slave));

  // Hand-computed columns from seed 16'hACE1, mask 16'hB400.
  int col_left [8] = '{400, 576, 760, 916, 1058, 1225, 1372, 1509};
  int col_top  [8] = '{212, 266, 153,  96,   68,   54,  219,  277};
  int col_bot  [8] = '{228, 174, 287, 344,  372,  386,  221,  163};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rec(input int l, input int h, input bit top);
    blk_rec_t r;
    r.left   = 16'(l);
    r.right  = 16'(l + 31);
    r.height = 16'(h);
    r.stat   = top ? STAT_TOP : STAT_BOT;
    return 64'(r);
  endfunction

  task automatic peek_col(input int slot, input int col);
    logic [4:0] saved;
    saved = if_a.i_rd_addr;
    if_a.i_rd_addr = 5'(slot);
    #1 check($sformatf("slot%0d_bot", slot), 64'(if_a.o_rd_data), rec(col_left[col], col_bot[col], 1'b0));
    if_a.i_rd_addr = 5'(slot + 1);
    #1 check($sformatf("slot%0d_top", slot + 1), 64'(if_a.o_rd_data), rec(col_left[col], col_top[col], 1'b1));
    if_a.i_rd_addr = saved;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hb, ht;
    int cyc;

    rst = 1'b1;
    if_a.i_start = 1'b1; if_a.i_rd_addr = '0;
    if_b.i_start = 1'b0; if_b.i_rd_addr = '0;
    step(); step();
    check("rst_ready", 64'(if_a.o_ready), 64'd0);
    check("rst_end",   64'(if_a.o_end),   64'd0);
    check("rst_state", 64'(dut_a.state_q), 64'(ST_IDLE));
    check("rst_wrptr", 64'(dut_a.wr_ptr_q), 64'd0);

    rst = 1'b0; if_a.i_start = 1'b0;
    step();
    check("idle_after_rst", 64'(dut_a.state_q), 64'(ST_IDLE));

    // Initial fill.
    if_a.i_start = 1'b1;
    step();
    if_a.i_start = 1'b0;
    cyc = 1;
    while (!if_a.o_ready && cyc < 9) begin
      step();
      cyc++;
    end
    check("fill_ready", 64'(if_a.o_ready), 64'd1);
    check("fill_within_9", 64'(cyc <= 9), 64'd1);
    check("fill_occ", 64'(dut_a.occ_q), 64'd8);
    check("fill_state", 64'(dut_a.state_q), 64'(ST_WAIT));
    for (int c = 0; c < 4; c++) peek_col(2 * c, c);
    if_a.i_rd_addr = 5'd0;
    #1 hb = if_a.o_rd_data[HEIGHT_LSB +: 16];
    if_a.i_rd_addr = 5'd1;
    #1 ht = if_a.o_rd_data[HEIGHT_LSB +: 16];
    if_a.i_rd_addr = 5'd0;
    check("pair_sum", 64'(32'(hb) + 32'(ht) + 160), 64'd600);

    // One consume: below refill threshold not yet reached.
    if_a.i_rd_addr = 5'd1; step();
    check("cons1_occ", 64'(dut_a.occ_q), 64'd7);
    check("cons1_nowrite", 64'(dut_a.wr_ptr_q), 64'd0);
    if_a.i_rd_addr = 5'd2; step();
    check("cons2_occ", 64'(dut_a.occ_q), 64'd6);
    step(); step();
    check("refill_occ", 64'(dut_a.occ_q), 64'd8);
    check("refill_wrptr", 64'(dut_a.wr_ptr_q), 64'd2);
    peek_col(0, 4);

    // Consume every cycle while refilling, including the 7 -> 0 wrap.
    if_a.i_rd_addr = 5'd3; step();
    check("tog_occ7", 64'(dut_a.occ_q), 64'd7);
    if_a.i_rd_addr = 5'd4; step();
    check("tog_occ6", 64'(dut_a.occ_q), 64'd6);
    if_a.i_rd_addr = 5'd5; step();
    check("simul_wr_cons_bot", 64'(dut_a.occ_q), 64'd6);
    if_a.i_rd_addr = 5'd6; step();
    check("simul_wr_cons_top", 64'(dut_a.occ_q), 64'd6);
    if_a.i_rd_addr = 5'd7; step();
    if_a.i_rd_addr = 5'd0; step();
    check("wrap_cons_occ", 64'(dut_a.occ_q), 64'd6);
    check("wrap_wrptr", 64'(dut_a.wr_ptr_q), 64'd6);
    step(); step();
    check("after_wrap_occ", 64'(dut_a.occ_q), 64'd8);
    check("after_wrap_wrptr", 64'(dut_a.wr_ptr_q), 64'd0);
    check("after_wrap_state", 64'(dut_a.state_q), 64'(ST_WAIT));
    peek_col(2, 5);
    peek_col(4, 6);
    peek_col(6, 7);

    // Reset asserted while a top block is being written.
    if_a.i_rd_addr = 5'd1; step();
    if_a.i_rd_addr = 5'd2; step();
    step();
    check("pre_rst_state", 64'(dut_a.state_q), 64'(ST_GEN_TOP));
    rst = 1'b1;
    #1;
    check("async_rst_ready", 64'(if_a.o_ready), 64'd0);
    check("async_rst_end",   64'(if_a.o_end),   64'd0);
    check("async_rst_occ",   64'(dut_a.occ_q),  64'd0);
    step(); step();
    rst = 1'b0; if_a.i_rd_addr = '0;
    step(); step(); step();
    check("post_rst_idle", 64'(dut_a.state_q), 64'(ST_IDLE));
    check("post_rst_wrptr", 64'(dut_a.wr_ptr_q), 64'd0);

    // Coordinate overflow on the very first column.
    if_b.i_start = 1'b1; step();
    if_b.i_start = 1'b0;
    check("ovf_genbot", 64'(dut_b.state_q), 64'(ST_GEN_BOT));
    check("ovf_end_early", 64'(if_b.o_end), 64'd0);
    step();
    check("ovf_end", 64'(if_b.o_end), 64'd1);
    check("ovf_nowrite", 64'(dut_b.wr_ptr_q), 64'd0);
    check("ovf_occ", 64'(dut_b.occ_q), 64'd0);
    if_b.i_start = 1'b1; step();
    if_b.i_start = 1'b0; step();
    check("end_terminal", 64'(dut_b.state_q), 64'(ST_END));
    check("end_ready", 64'(if_b.o_ready), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
